// File: rtl/gray_sobel_edge.sv
// Sobel edge detector on a gray RGB565 stream: two line buffers feed a 3x3 window,
// |Gx|+|Gy| is thresholded to a white/black pixel, with a fixed 4-cycle latency.
module gray_sobel_edge #(
    parameter int unsigned H_ACTIVE = 640,
    parameter logic [7:0]  THRESH   = 8'd40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic        in_valid,
    input  logic [15:0] in_rgb,
    input  logic        bypass,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_valid,
    output logic [15:0] out_rgb
);
    localparam int unsigned CW = (H_ACTIVE > 2) ? $clog2(H_ACTIVE) : 2;
    localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);

    typedef enum logic {WAIT_FRAME, RUN} state_t;
    state_t state, state_next;
    logic   run_en;

    logic [CW-1:0] col;
    logic          line_full;
    logic [9:0]    row;
    logic          vsync_d, valid_d;
    logic          vsync_fall, valid_fall, accept, border;
    logic [7:0]    luma, rd0, rd1;

    logic [7:0] lb0 [H_ACTIVE];
    logic [7:0] lb1 [H_ACTIVE];
    logic [7:0] win [3][3];

    logic [3:0]  hs_pipe, vs_pipe, vd_pipe;
    logic        s1_edge;
    logic [15:0] s1_byp_rgb, s2_rgb, s3_rgb;

    logic signed [10:0] gx, gy;
    logic [10:0]        ax, ay;
    logic [11:0]        mag_sum;
    logic [7:0]         mag;

    assign vsync_fall = vsync_d & ~in_vsync;
    assign valid_fall = valid_d & ~in_valid;
    assign accept     = in_valid & ~line_full;
    assign luma       = {in_rgb[10:5], in_rgb[10:9]};
    assign border     = (row < 10'd2) || (32'(col) < 32'd2);
    assign rd0        = lb0[col];
    assign rd1        = lb1[col];

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_FRAME;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == WAIT_FRAME && vsync_fall) state_next = RUN;
    end

    always_comb begin
        run_en = (state == RUN);
    end

    // Counters and window; a vsync fall wins over a coincident valid fall for row.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            line_full <= 1'b0;
            row       <= '0;
            vsync_d   <= 1'b1;
            valid_d   <= 1'b0;
            for (int unsigned i = 0; i < 3; i++)
                for (int unsigned j = 0; j < 3; j++)
                    win[i][j] <= '0;
        end else begin
            vsync_d <= in_vsync;
            valid_d <= in_valid;
            if (valid_fall) begin
                col       <= '0;
                line_full <= 1'b0;
            end else if (accept) begin
                if (col == COL_LAST) line_full <= 1'b1;
                else                 col <= col + 1'b1;
            end
            if (vsync_fall)                          row <= '0;
            else if (valid_fall && row != 10'd1023) row <= row + 1'b1;
            if (accept) begin
                for (int unsigned i = 0; i < 3; i++) begin
                    win[i][0] <= win[i][1];
                    win[i][1] <= win[i][2];
                end
                win[0][2] <= rd1;
                win[1][2] <= rd0;
                win[2][2] <= luma;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && run_en && !rst) begin
            lb0[col] <= luma;
            lb1[col] <= lb0[col];
        end
    end

    always_comb begin
        gx = (signed'({3'b000, win[0][2]}) + signed'({2'b00, win[1][2], 1'b0}) + signed'({3'b000, win[2][2]}))
           - (signed'({3'b000, win[0][0]}) + signed'({2'b00, win[1][0], 1'b0}) + signed'({3'b000, win[2][0]}));
        gy = (signed'({3'b000, win[2][0]}) + signed'({2'b00, win[2][1], 1'b0}) + signed'({3'b000, win[2][2]}))
           - (signed'({3'b000, win[0][0]}) + signed'({2'b00, win[0][1], 1'b0}) + signed'({3'b000, win[0][2]}));
        ax      = gx[10] ? 11'(-gx) : 11'(gx);
        ay      = gy[10] ? 11'(-gy) : 11'(gy);
        mag_sum = {1'b0, ax} + {1'b0, ay};
        mag     = (mag_sum > 12'd255) ? 8'hFF : mag_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe    <= '1;
            vs_pipe    <= '1;
            vd_pipe    <= '0;
            s1_edge    <= 1'b0;
            s1_byp_rgb <= '0;
            s2_rgb     <= '0;
            s3_rgb     <= '0;
            out_rgb    <= '0;
        end else begin
            hs_pipe    <= {hs_pipe[2:0], in_hsync};
            vs_pipe    <= {vs_pipe[2:0], in_vsync};
            vd_pipe    <= {vd_pipe[2:0], in_valid};
            s1_edge    <= accept & run_en & ~bypass & ~border;
            s1_byp_rgb <= (accept && run_en && bypass) ? in_rgb : '0;
            s2_rgb     <= s1_edge ? ((mag >= THRESH) ? '1 : '0) : s1_byp_rgb;
            s3_rgb     <= s2_rgb;
            out_rgb    <= s3_rgb;
        end
    end

    assign out_hsync = hs_pipe[3];
    assign out_vsync = vs_pipe[3];
    assign out_valid = vd_pipe[3];
endmodule

// File: tb/tb_gray_sobel_edge.sv
// Randomized frame-level bench for gray_sobel_edge; expected pixels come from a frame
// image and direct Sobel arithmetic, delayed through a 4-deep expectation queue.
module tb_gray_sobel_edge;
    localparam int H    = 16;
    localparam int MAXR = 32;
    localparam int TH   = 40;

    logic        clk = 1'b0;
    logic        rst, in_hsync, in_vsync, in_valid, bypass;
    logic [15:0] in_rgb;
    logic        out_hsync, out_vsync, out_valid;
    logic [15:0] out_rgb;

    gray_sobel_edge #(.H_ACTIVE(H), .THRESH(8'd40)) dut (
        .clk(clk), .rst(rst), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_valid(in_valid), .in_rgb(in_rgb), .bypass(bypass),
        .out_hsync(out_hsync), .out_vsync(out_vsync), .out_valid(out_valid), .out_rgb(out_rgb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int         mrow, mcol;
    bit         mrun, mfull, pv_vs, pv_valid;
    int         img [MAXR][H];
    logic [18:0] pipe [4];
    localparam logic [18:0] RST_T = {1'b1, 1'b1, 1'b0, 16'h0000};

    function automatic int luma_of(input logic [15:0] rgb);
        int g;
        g = (int'(rgb) >> 5) & 63;
        return g * 4 + g / 16;
    endfunction

    function automatic logic [15:0] gray(input int g);
        logic [5:0] g6;
        g6 = 6'(g);
        return {g6[5:1], g6, g6[5:1]};
    endfunction

    function automatic int sobel_mag(input int r, input int c);
        int gx, gy, m;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c]) - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 255 : m;
    endfunction

    task automatic model_edge(input logic hs, input logic vs, input logic vd,
                              input logic [15:0] rgb, input logic byp, input logic r);
        logic [15:0] e;
        bit acc;
        if (r) begin
            mrow = 0; mcol = 0; mrun = 0; mfull = 0; pv_vs = 1; pv_valid = 0;
            for (int i = 0; i < 4; i++) pipe[i] = RST_T;
            return;
        end
        e = 16'h0000;
        acc = vd && !mfull;
        if (acc && mrun && mrow < MAXR) begin
            img[mrow][mcol] = luma_of(rgb);
            if (byp) e = rgb;
            else if (mrow >= 2 && mcol >= 2) e = (sobel_mag(mrow, mcol) >= TH) ? 16'hFFFF : 16'h0000;
        end
        if (acc) begin
            if (mcol == H - 1) mfull = 1;
            else mcol++;
        end
        if (pv_valid && !vd) begin mcol = 0; mfull = 0; end
        if (pv_vs && !vs) begin mrow = 0; mrun = 1; end
        else if (pv_valid && !vd && mrow < 1023) mrow++;
        pv_vs = vs; pv_valid = vd;
        for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {hs, vs, vd, e};
    endtask

    task automatic step(input logic hs, input logic vs, input logic vd,
                        input logic [15:0] rgb, input logic byp, input logic r);
        in_hsync = hs; in_vsync = vs; in_valid = vd; in_rgb = rgb; bypass = byp; rst = r;
        @(posedge clk);
        model_edge(hs, vs, vd, rgb, byp, r);
        #1;
        check("hsync", 32'(out_hsync), 32'(pipe[3][18]));
        check("vsync", 32'(out_vsync), 32'(pipe[3][17]));
        check("valid", 32'(out_valid), 32'(pipe[3][16]));
        check("rgb",   32'(out_rgb),   32'(pipe[3][15:0]));
    endtask

    function automatic logic [15:0] pix(input int kind, input int r, input int c);
        case (kind)
            0: return 16'h8410;
            1: return (c < H/2) ? 16'h0000 : gray(63);
            2: return (r < 4) ? 16'h0000 : gray(63);
            4: return (r == 4 && c == 5) ? gray(5) : (r == 7 && c == 10) ? gray(4) : 16'h0000;
            5: return 16'(c);
            6: return (c < H/2) ? 16'h0000 : gray(16);
            default: return 16'($urandom);
        endcase
    endfunction

    // byp_mode: 0 off, 1 on, 2 random per pixel; rst_row >= 0 pulses reset mid-line
    task automatic frame(input int kind, input int nrows, input int byp_mode,
                         input int rst_row, input bit tight_end);
        logic b;
        repeat (3) step(1, 0, 0, 16'h0, 0, 0);
        repeat (3) step(1, 1, 0, 16'h0, 0, 0);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < H; c++) begin
                b = (byp_mode == 2) ? 1'($urandom) : (byp_mode == 1);
                step(1, 1, 1, pix(kind, r, c), b, (r == rst_row && c == H/2));
            end
            if (!(tight_end && r == nrows - 1)) begin
                repeat (2) step(1, 1, 0, 16'h0, 0, 0);
                repeat (2) step(0, 1, 0, 16'h0, 0, 0);
                repeat (2) step(1, 1, 0, 16'h0, 0, 0);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < MAXR; r++)
            for (int c = 0; c < H; c++) img[r][c] = 0;
        repeat (3) step(1, 1, 0, 16'h0, 0, 1);
        repeat (2) step(1, 1, 0, 16'h0, 0, 0);
        frame(0, 8, 0, -1, 0);   // uniform gray
        frame(1, 8, 0, -1, 0);   // vertical step
        frame(2, 8, 0, -1, 0);   // horizontal step
        frame(4, 10, 0, -1, 0);  // impulses at the threshold
        frame(6, 6, 0, -1, 0);   // step beyond 255 saturates
        frame(3, 8, 0, -1, 0);   // random pixels
        frame(5, 5, 1, -1, 0);   // bypass ramp
        frame(3, 8, 2, -1, 0);   // random bypass toggling
        frame(3, 10, 0, 5, 0);   // reset mid-frame
        frame(1, 8, 0, -1, 0);   // recovers after next vsync
        frame(3, 6, 0, -1, 1);   // last valid fall meets next vsync fall
        frame(3, 8, 0, -1, 0);
        repeat (8) step(1, 1, 0, 16'h0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gray_sobel_edge.md
GRAY_SOBEL_EDGE -- requirements
Module: gray_sobel_edge

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line; sets line-buffer depth.
REQ-002 Parameter THRESH, default 8'd40: edge magnitude threshold.
REQ-003 Port clk  input  1  pixel clock (25 MHz domain); the block uses one clock only.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_hsync  input  1  horizontal sync from the gray stage, active-low.
REQ-006 Port in_vsync  input  1  vertical sync from the gray stage, active-low.
REQ-007 Port in_valid  input  1  active-video qualifier; high for exactly H_ACTIVE contiguous cycles per line.
REQ-008 Port in_rgb  input  16  RGB565 gray pixel (R=G=B).
REQ-009 Port bypass  input  1  when high, the output is the delayed input pixel instead of the edge map.
REQ-010 Port out_hsync  output  1  in_hsync delayed by LAT.
REQ-011 Port out_vsync  output  1  in_vsync delayed by LAT.
REQ-012 Port out_valid  output  1  in_valid delayed by LAT.
REQ-013 Port out_rgb  output  16  edge-map pixel, 16'hFFFF (edge) or 16'h0000.

Function
REQ-014 Luma shall be {in_rgb[10:5], in_rgb[10:9]} (8 bits), sampled only when in_valid=1.
REQ-015 LAT shall be exactly 4 clk cycles for out_hsync, out_vsync, out_valid and out_rgb.
REQ-016 A column counter col shall increment on each in_valid cycle and clear on the first cycle with in_valid=0 after in_valid=1.
REQ-017 col shall saturate at H_ACTIVE-1; samples beyond that shall be ignored, with no line-buffer write.
REQ-018 A row counter row shall increment once per line, on the in_valid falling edge.
REQ-019 row shall clear on the in_vsync falling edge and saturate at 1023.
REQ-020 Two line buffers of H_ACTIVE x 8 bits: at sample col, lb1[col] <= lb0[col] and lb0[col] <= luma.
REQ-021 The read of the old lb0 and lb1 contents shall occur in the same cycle as the write (read-before-write).
REQ-022 The 3x3 window shall hold rows {lb1, lb0, luma}, shifted one column per in_valid sample; the window centre is pixel (col-1, row-1).
REQ-023 Gx shall be (p02+2*p12+p22)-(p00+2*p10+p20), and Gy shall be (p20+2*p21+p22)-(p00+2*p01+p02), as 11-bit signed values.
REQ-024 Magnitude mag = |Gx|+|Gy|, saturated to 255.
REQ-025 Edge decision: out_rgb = 16'hFFFF if mag >= THRESH, else 16'h0000.
REQ-026 Border: when row<2 or col<2 at sample time, out_rgb shall be 16'h0000 regardless of mag.
REQ-027 out_rgb shall be 16'h0000 whenever out_valid=0.
REQ-028 With bypass=1, out_rgb shall equal in_rgb delayed by LAT, while syncs and valid keep the same LAT.
REQ-029 bypass shall be sampled per pixel at input time, so a change takes effect on the pixel output LAT cycles later.
REQ-030 FSM states: WAIT_FRAME and RUN.
REQ-031 WAIT_FRAME -> RUN on the in_vsync falling edge; RUN stays until reset.
REQ-032 In WAIT_FRAME, out_rgb shall be 16'h0000 and there shall be no line-buffer writes; syncs and valid still propagate with LAT.
REQ-033 An in_vsync falling edge during RUN shall clear row only; line-buffer contents need not be cleared because the border rule masks them.
REQ-034 An in_valid falling edge coinciding with the in_vsync falling edge: the col clear and the row clear both apply, and row ends at 0, not 1.

Reset
REQ-035 While rst=1 at a clk edge: state=WAIT_FRAME, col=0, row=0, window=0, delay pipelines cleared.
REQ-036 Output reset values: out_hsync=1, out_vsync=1, out_valid=0, out_rgb=16'h0000.
REQ-037 Line-buffer RAM contents are not reset.
REQ-038 A reset asserted mid-frame shall abort the current frame; edge output resumes only after the next in_vsync falling edge.

Verification
REQ-039 Uniform frame, all pixels 16'h8410 (luma 0x82), bypass=0 -> every out_rgb=0x0000 and out_valid matches in_valid shifted 4 cycles.
REQ-040 Vertical step (luma 0 for col<320, 0xFF for col>=320) -> out_rgb=0xFFFF exactly at output columns 319 and 320 for rows>=2, elsewhere 0.
REQ-041 Horizontal step at row 100 -> 0xFFFF on output rows 99 and 100 only; rows 0-1 and columns 0-1 stay 0x0000 (border).
REQ-042 bypass=1 with a ramp in_rgb=col -> out_rgb equals in_rgb from exactly 4 cycles earlier, and syncs are aligned.
REQ-043 Reset pulsed at row 200 -> outputs at reset values next cycle; the remainder of the frame gives out_rgb=0 while syncs propagate; the next frame gives normal edges.
REQ-044 THRESH boundary: window producing mag=40 -> 0xFFFF; mag=39 -> 0x0000; mag>255 saturates -> 0xFFFF.
